// File: rtl/mtrx_slice_streamer_pkg.sv
// Shared definitions for the matrix slice streamer.
//   - Fallback values for the shared hyper-parameter macros, used only when
//     the project-wide include has not already defined them.
//   - Top-level FSM state type.
//   - Helper that sizes channel-ID fields.

`ifndef SYSTOLIC_DATA_WIDTH
`define SYSTOLIC_DATA_WIDTH 16
`endif

`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

package mtrx_slice_streamer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } streamState_t;

  // Width of a channel-ID field. This is never zero, so the field is still
  // legal when only one channel exists.
  function automatic int chWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/mtrx_slice_streamer_if.sv
// Bus bundle between the slice streamer and its surroundings.
//   mem_rd_en / mem_rd_addr : shared read request (streamer -> memory)
//   mem_rd_data             : read data, valid one cycle after mem_rd_en
//   m_valid/m_last/m_ready  : one bit per channel, valid/ready stream
//   m_data                  : NUM_CH concatenated beats, channel 0 in the LSBs
// The master modport is the streamer. The slave modport is the memory and
// the stream sinks.

interface mtrx_slice_streamer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = `SYSTOLIC_DATA_WIDTH,
  parameter int ADDR_W = `ADDR_SIZE
);
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_rd_addr;
  logic [DATA_W-1:0]        mem_rd_data;
  logic [NUM_CH-1:0]        m_valid;
  logic [NUM_CH-1:0]        m_last;
  logic [NUM_CH-1:0]        m_ready;
  logic [NUM_CH*DATA_W-1:0] m_data;

  modport master (
    output mem_rd_en, mem_rd_addr, m_valid, m_last, m_data,
    input  mem_rd_data, m_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, m_valid, m_last, m_data,
    output mem_rd_data, m_ready
  );
endinterface

// File: rtl/mtrx_slice_streamer_slice_fifo.sv
// slice_fifo: a small synchronous FIFO that holds one channel's beats.
// Reads are first-word-fall-through: rdData always shows the head entry.
//   s_clk, s_rst : clock, asynchronous active-high reset
//   wrEn, wrData : push (the caller guarantees the FIFO is not full)
//   rdEn         : pop (the caller guarantees the FIFO is not empty)
//   rdData       : head entry
//   count        : current occupancy, 0..DEPTH

module slice_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             s_clk,
  input  logic             s_rst,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  // NOTE: the storage array is deliberately left without a reset. Only the
  // pointers and the count decide what is visible, so stale contents can
  // never reach the output.
  always_ff @(posedge s_clk) begin
    if (wrEn) storage[wrPtr] <= wrData;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_W'(1);
      if (rdEn) rdPtr <= rdPtr + PTR_W'(1);
      case ({wrEn, rdEn})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign rdData = storage[rdPtr];
endmodule

// File: rtl/mtrx_slice_streamer.sv
// mtrx_slice_streamer: streams NUM_CH matrix slices out of one shared
// read port. Each slice is a run of cfg_len consecutive words starting at
// that channel's base address. Each channel has its own valid/ready output,
// and a small per-channel FIFO decouples the outputs from one another.
//   s_clk, s_rst : clock, asynchronous active-high reset
//   start        : launch pulse, accepted only while idle
//   cfg_base     : per-channel base address (channel 0 in the LSBs)
//   cfg_len      : beats per channel
//   busy, done   : transfer in progress / one-cycle completion pulse
//   bus          : memory read port and per-channel output streams

module mtrx_slice_streamer
  import mtrx_slice_streamer_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = `SYSTOLIC_DATA_WIDTH,
  parameter int ADDR_W     = `ADDR_SIZE,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     s_clk,
  input  logic                     s_rst,
  input  logic                     start,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]         cfg_len,
  output logic                     busy,
  output logic                     done,
  mtrx_slice_streamer_if.master    bus
);
  localparam int CH_W  = chWidth(NUM_CH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  streamState_t      state;
  logic [LEN_W-1:0]  lenReg;
  logic [ADDR_W-1:0] baseReg   [NUM_CH];
  logic [LEN_W-1:0]  issuedCnt [NUM_CH];
  logic [LEN_W-1:0]  sentCnt   [NUM_CH];
  logic [CH_W-1:0]   rrPtr;

  // The read pipeline has two stages. Stage 1 is the request, which is
  // visible on the memory port. Stage 2 is the returning data, which is
  // written into the grantee's FIFO.
  logic              rdEnQ;
  logic [ADDR_W-1:0] rdAddrQ;
  logic [CH_W-1:0]   rdTagQ;
  logic              rdLastQ;
  logic              wrEnQ;
  logic [CH_W-1:0]   wrTagQ;
  logic              wrLastQ;

  logic [NUM_CH-1:0]        eligible;
  logic [NUM_CH-1:0]        popBeat;
  logic [NUM_CH-1:0]        chFinished;
  logic [NUM_CH-1:0]        mValid;
  logic [NUM_CH-1:0]        mLast;
  logic [NUM_CH*DATA_W-1:0] mData;

  logic            grantValid;
  logic [CH_W-1:0] grantCh;
  logic [CH_W-1:0] candCh;

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    localparam logic [CH_W-1:0] ID = CH_W'(g);

    logic [CNT_W-1:0] fifoCnt;
    logic [DATA_W:0]  fifoHead;
    logic [OCC_W-1:0] occupancy;
    logic             pushBeat;

    assign pushBeat = wrEnQ && (wrTagQ == ID);

    // Credit check. Every read still in the pipeline already owns a FIFO
    // slot, so the FIFO cannot overflow whatever the sink does.
    assign occupancy = OCC_W'(fifoCnt) + OCC_W'(rdEnQ && (rdTagQ == ID))
                     + OCC_W'(pushBeat);
    assign eligible[g] = (state == S_RUN) && (issuedCnt[g] < lenReg)
                       && (occupancy < OCC_W'(FIFO_DEPTH));

    // Data and last are forced to zero while the FIFO is empty, so that
    // outputs read zero in and just after reset.
    assign mValid[g]                 = (fifoCnt != '0);
    assign mLast[g]                  = mValid[g] && fifoHead[DATA_W];
    assign mData[g*DATA_W +: DATA_W] = mValid[g] ? fifoHead[DATA_W-1:0] : '0;
    assign popBeat[g]                = mValid[g] && bus.m_ready[g];
    assign chFinished[g]             = (sentCnt[g] == lenReg);

    slice_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
    ) uFifo (
      .s_clk  (s_clk),
      .s_rst  (s_rst),
      .wrEn   (pushBeat),
      .wrData ({wrLastQ, bus.mem_rd_data}),
      .rdEn   (popBeat[g]),
      .rdData (fifoHead),
      .count  (fifoCnt)
    );
  end

  // Round-robin arbiter. The search starts at rrPtr, and the first eligible
  // channel found wins the read.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value held over and no latch is inferred.
    grantValid = 1'b0;
    grantCh    = '0;
    candCh     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      candCh = CH_W'((int'(rrPtr) + i) % NUM_CH);
      if (!grantValid && eligible[candCh]) begin
        grantValid = 1'b1;
        grantCh    = candCh;
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments. Every register then
  // samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      lenReg  <= '0;
      rrPtr   <= '0;
      rdEnQ   <= 1'b0;
      rdAddrQ <= '0;
      rdTagQ  <= '0;
      rdLastQ <= 1'b0;
      wrEnQ   <= 1'b0;
      wrTagQ  <= '0;
      wrLastQ <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        baseReg[c]   <= '0;
        issuedCnt[c] <= '0;
        sentCnt[c]   <= '0;
      end
    end else begin
      rdEnQ   <= 1'b0;
      done    <= 1'b0;
      wrEnQ   <= rdEnQ;
      wrTagQ  <= rdTagQ;
      wrLastQ <= rdLastQ;
      for (int c = 0; c < NUM_CH; c++) begin
        if (popBeat[c]) sentCnt[c] <= sentCnt[c] + LEN_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            lenReg <= cfg_len;
            for (int c = 0; c < NUM_CH; c++) begin
              baseReg[c]   <= cfg_base[c*ADDR_W +: ADDR_W];
              issuedCnt[c] <= '0;
              sentCnt[c]   <= '0;
            end
          end
        end

        S_RUN: begin
          if (grantValid) begin
            rdEnQ              <= 1'b1;
            rdAddrQ            <= baseReg[grantCh] + ADDR_W'(issuedCnt[grantCh]);
            rdTagQ             <= grantCh;
            rdLastQ            <= (issuedCnt[grantCh] == lenReg - LEN_W'(1));
            issuedCnt[grantCh] <= issuedCnt[grantCh] + LEN_W'(1);
            rrPtr              <= (grantCh == CH_W'(NUM_CH - 1)) ? '0
                                                                 : grantCh + CH_W'(1);
          end
          // A channel can only finish once every read it issued has been
          // delivered, so no read can still be in flight at this point.
          if (&chFinished) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en   = rdEnQ;
  assign bus.mem_rd_addr = rdAddrQ;
  assign bus.m_valid     = mValid;
  assign bus.m_last      = mLast;
  assign bus.m_data      = mData;
endmodule
